// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Round-robin arbiter that lets NUM_REQ byte producers share one transmit UART.
// A requester owns the UART for one message (ending on req_last) or MAX_BURST
// bytes, whichever comes first; an idle cycle always separates two owners.
//
// Optional feature: define UART_ARB_TIMEOUT_EN to release an owner that has
// kept req_valid low for IDLE_TIMEOUT consecutive owned cycles. That release
// pulses timeout_evt for one cycle. Without the macro an owner holds the
// grant indefinitely and timeout_evt is constant 0.
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int MAX_BURST    = 16,
    parameter int IDLE_TIMEOUT = 1024
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [8*NUM_REQ-1:0]   req_data,
    input  logic [NUM_REQ-1:0]     req_last,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic                   tx_ready,
    output logic                   tx_valid,
    output logic [7:0]             tx_data,
    output logic [NUM_REQ-1:0]     grant,
    output logic                   timeout_evt
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_BURST - 1);
    localparam bit CFG_OK = (NUM_REQ >= 2) && (NUM_REQ <= 8) &&
                            (MAX_BURST >= 1) && (MAX_BURST <= 255) &&
                            (IDLE_TIMEOUT >= 1);

    // An illegal parameter set fails elaboration on the missing module below.
    generate
        if (!CFG_OK) begin : g_cfg_err
            uart_tx_arbiter_illegal_parameters u_cfg_err ();
        end
    endgenerate

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_OWN  = 1'b1
    } state_t;

    state_t               state_reg;
    logic [NUM_REQ-1:0]   grant_reg;
    logic [IDX_W-1:0]     owner_reg;
    logic [IDX_W-1:0]     rr_ptr_reg;
    logic [CNT_W-1:0]     burst_cnt_reg;

    // Per-requester byte view of the packed data bus.
    logic [7:0] req_byte [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_byte
            assign req_byte[gi] = req_data[8*gi +: 8];
        end
    endgenerate

    // Round-robin search: lowest offset from rr_ptr with a valid request wins.
    // Scanning offsets from high to low lets the last hit be the winner.
    logic             arb_found;
    logic [IDX_W-1:0] arb_idx;
    logic [IDX_W:0]   cand_sum;
    logic [IDX_W-1:0] cand_idx;

    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        cand_sum  = '0;
        cand_idx  = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand_sum = {1'b0, rr_ptr_reg} + (IDX_W+1)'(k);
            if (cand_sum >= (IDX_W+1)'(NUM_REQ)) begin
                cand_sum = cand_sum - (IDX_W+1)'(NUM_REQ);
            end
            cand_idx = cand_sum[IDX_W-1:0];
            if (req_valid[cand_idx]) begin
                arb_found = 1'b1;
                arb_idx   = cand_idx;
            end
        end
    end

    // One-hot form of the arbitration winner, loaded into grant on a new grant.
    logic [NUM_REQ-1:0] arb_onehot;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_onehot
            assign arb_onehot[gi] = arb_found && (arb_idx == IDX_W'(gi));
        end
    endgenerate

    // Owner-side handshake and release decisions.
    logic           own;
    logic           owner_valid;
    logic           owner_last;
    logic           xfer;
    logic           burst_done;
    logic           rel_now;
    logic           stall_expire;
    logic [IDX_W:0] rr_sum;
    logic [IDX_W-1:0] rr_next;

    assign own         = (state_reg == ST_OWN);
    assign owner_valid = req_valid[owner_reg];
    assign owner_last  = req_last[owner_reg];
    assign xfer        = own && owner_valid && tx_ready;
    assign burst_done  = (burst_cnt_reg == BURST_LAST);
    // Message end and burst limit on the same byte still give one release.
    assign rel_now     = xfer && (owner_last || burst_done);
    assign rr_sum      = {1'b0, owner_reg} + (IDX_W+1)'(1);
    assign rr_next     = (rr_sum == (IDX_W+1)'(NUM_REQ)) ? '0 : rr_sum[IDX_W-1:0];

    // Datapath is a pure mux: the owner talks straight to the UART.
    assign grant     = grant_reg;
    assign tx_valid  = own && owner_valid;
    assign tx_data   = own ? req_byte[owner_reg] : 8'h00;
    assign req_ready = grant_reg & {NUM_REQ{tx_ready}};

`ifdef UART_ARB_TIMEOUT_EN
    localparam int STALL_W = $clog2(IDLE_TIMEOUT + 1);
    localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(IDLE_TIMEOUT - 1);

    logic [STALL_W-1:0] stall_cnt_reg;
    logic               timeout_evt_reg;

    // The cycle that would bring the stall count to IDLE_TIMEOUT forces release.
    assign stall_expire = own && !owner_valid && (stall_cnt_reg == STALL_LAST);

    // Stall counter: counts owned cycles with the owner silent, clears otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_reg <= '0;
        end else if (!own || owner_valid || stall_expire) begin
            stall_cnt_reg <= '0;
        end else begin
            stall_cnt_reg <= stall_cnt_reg + STALL_W'(1);
        end
    end

    // One-cycle event flag aligned with the grant dropping.
    always_ff @(posedge clk) begin
        if (reset) begin
            timeout_evt_reg <= 1'b0;
        end else begin
            timeout_evt_reg <= stall_expire;
        end
    end

    assign timeout_evt = timeout_evt_reg;
`else
    assign stall_expire = 1'b0;
    assign timeout_evt  = 1'b0;
`endif

    // Ownership FSM: grant, owner index, round-robin pointer and burst count.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            grant_reg     <= '0;
            owner_reg     <= '0;
            rr_ptr_reg    <= '0;
            burst_cnt_reg <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (arb_found) begin
                        state_reg     <= ST_OWN;
                        grant_reg     <= arb_onehot;
                        owner_reg     <= arb_idx;
                        burst_cnt_reg <= '0;
                    end
                end
                ST_OWN: begin
                    if (xfer) begin
                        burst_cnt_reg <= burst_cnt_reg + CNT_W'(1);
                    end
                    if (rel_now || stall_expire) begin
                        state_reg  <= ST_IDLE;
                        grant_reg  <= '0;
                        rr_ptr_reg <= rr_next;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    grant_reg <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios followed by a random phase, all
// checked cycle by cycle against a transaction-level model of the arbiter.
// Honours UART_ARB_TIMEOUT_EN the same way the design does.
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int MB = 16;
    localparam int TO = 8;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [N-1:0]     req_valid = '0;
    logic [8*N-1:0]   req_data = '0;
    logic [N-1:0]     req_last = '0;
    logic [N-1:0]     req_ready;
    logic             tx_ready = 1'b0;
    logic             tx_valid;
    logic [7:0]       tx_data;
    logic [N-1:0]     grant;
    logic             timeout_evt;

    uart_tx_arbiter #(
        .NUM_REQ      (N),
        .MAX_BURST    (MB),
        .IDLE_TIMEOUT (TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .tx_ready    (tx_ready),
        .tx_valid    (tx_valid),
        .tx_data     (tx_data),
        .grant       (grant),
        .timeout_evt (timeout_evt)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    bit checking = 1'b0;

    // Per-requester byte sources: {last, data} entries, consumed on handshake.
    logic [8:0]   mem [N][256];
    int           wr [N];
    int           rd [N];
    logic [N-1:0] en_mask = '0;

    // Reference model: who owns the UART (-1 = nobody), bytes sent this grant,
    // where the next search starts, silent owned cycles, timeout pulse.
    int m_owner = -1;
    int m_cnt   = 0;
    int m_rr    = 0;
    int m_stall = 0;
    bit m_tevt  = 1'b0;

    logic [N-1:0] hist [$];
    logic         th [$];
    logic [7:0]   cap [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_queues();
        for (int i = 0; i < N; i++) begin
            wr[i] = 0;
            rd[i] = 0;
        end
    endtask

    task automatic push(input int r, input logic [7:0] d, input logic l);
        mem[r][wr[r]] = {l, d};
        wr[r]++;
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (rd[i] < wr[i]) begin
                req_valid[i]       = en_mask[i];
                req_data[8*i +: 8] = mem[i][rd[i]][7:0];
                req_last[i]        = mem[i][rd[i]][8];
            end else begin
                req_valid[i]       = 1'b0;
                req_data[8*i +: 8] = 8'h00;
                req_last[i]        = 1'b0;
            end
        end
    endtask

    task automatic peek();
        drive();
        #1;
    endtask

    // One clock: check outputs mid-cycle against the model, then advance it.
    task automatic step();
        logic [N-1:0] eg;
        logic [N-1:0] er;
        logic         ev;
        logic [7:0]   ed;
        bit           xf;
        bit           lst;
        bit           fnd;
        int           idx;
        drive();
        #1;
        eg = '0;
        er = '0;
        ev = 1'b0;
        ed = 8'h00;
        if (m_owner >= 0) begin
            eg[m_owner] = 1'b1;
            ev = req_valid[m_owner];
            ed = req_data[8*m_owner +: 8];
            if (tx_ready) er[m_owner] = 1'b1;
        end
        if (checking) begin
            chk("grant", 32'(grant), 32'(eg));
            chk("tx_valid", 32'(tx_valid), 32'(ev));
            chk("tx_data", 32'(tx_data), 32'(ed));
            chk("req_ready", 32'(req_ready), 32'(er));
            chk("timeout_evt", 32'(timeout_evt), 32'(m_tevt));
            if (tx_valid === 1'b1 && tx_ready) cap.push_back(tx_data);
        end
        xf  = ev && tx_ready;
        lst = xf && req_last[m_owner];
        if (xf) rd[m_owner]++;
        @(posedge clk);
        #1;
        if (reset) begin
            m_owner = -1;
            m_rr    = 0;
            m_cnt   = 0;
            m_stall = 0;
            m_tevt  = 1'b0;
            checking = 1'b1;
        end else begin
            m_tevt = 1'b0;
            if (m_owner < 0) begin
                fnd = 1'b0;
                for (int k = 0; k < N; k++) begin
                    idx = (m_rr + k) % N;
                    if (!fnd && req_valid[idx]) begin
                        fnd = 1'b1;
                        m_owner = idx;
                        m_cnt = 0;
                        m_stall = 0;
                    end
                end
            end else if (xf) begin
                m_cnt++;
                m_stall = 0;
                if (lst || m_cnt == MB) begin
                    m_rr = (m_owner + 1) % N;
                    m_owner = -1;
                end
            end else if (req_valid[m_owner]) begin
                m_stall = 0;
            end else begin
`ifdef UART_ARB_TIMEOUT_EN
                m_stall++;
                if (m_stall == TO) begin
                    m_rr = (m_owner + 1) % N;
                    m_owner = -1;
                    m_stall = 0;
                    m_tevt = 1'b1;
                end
`endif
            end
        end
        hist.push_back(grant);
        th.push_back(timeout_evt);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_queues();
        en_mask = '0;
        tx_ready = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        logic [6:0] pat;
        int ones;
        int len;

        // Reset state.
        do_reset();
        peek();
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_tx_valid", 32'(tx_valid), 32'h0);
        chk("rst_req_ready", 32'(req_ready), 32'h0);
        chk("rst_timeout_evt", 32'(timeout_evt), 32'h0);

        // Requesters 0 and 2; 0 sends a 3-byte message, then 2 is served.
        push(0, 8'h11, 1'b0);
        push(0, 8'h22, 1'b0);
        push(0, 8'h33, 1'b1);
        push(2, 8'h44, 1'b0);
        push(2, 8'h55, 1'b1);
        en_mask = '1;
        hist.delete();
        cap.delete();
        repeat (6) step();
        chk("rr_first_grant", 32'(hist[0]), 32'h1);
        chk("rr_hold_grant", 32'(hist[2]), 32'h1);
        chk("rr_idle_gap", 32'(hist[3]), 32'h0);
        chk("rr_next_owner", 32'(hist[4]), 32'h4);
        chk("rr_byte0", 32'(cap[0]), 32'h11);
        chk("rr_byte2", 32'(cap[2]), 32'h33);

        // Requester 1 streams 20 bytes with no message end: capped at 16.
        do_reset();
        for (int k = 0; k < 20; k++) push(1, 8'(8'h80 + k), 1'b0);
        push(0, 8'hE0, 1'b1);
        push(2, 8'hE2, 1'b1);
        en_mask = 4'b0010;
        hist.delete();
        cap.delete();
        repeat (3) step();
        en_mask = '1;
        repeat (17) step();
        chk("burst_stream_len", 32'(cap.size()), 32'd17);
        for (int k = 0; k < 16; k++) chk("burst_byte", 32'(cap[k]), 32'(8'h80 + k));
        chk("burst_release", 32'(hist[16]), 32'h0);
        chk("burst_rr_ptr2", 32'(hist[17]), 32'h4);
        chk("burst_next_byte", 32'(cap[16]), 32'hE2);

        // UART back-pressure mid-message: 1,0,0,1 on tx_ready.
        do_reset();
        push(3, 8'hA5, 1'b0);
        push(3, 8'h5A, 1'b1);
        en_mask = '1;
        hist.delete();
        cap.delete();
        pat = 7'b1110011;
        for (int k = 0; k < 7; k++) begin
            tx_ready = pat[k];
            step();
        end
        chk("bp_count", 32'(cap.size()), 32'd2);
        chk("bp_byte0", 32'(cap[0]), 32'hA5);
        chk("bp_byte1", 32'(cap[1]), 32'h5A);
        chk("bp_grant_frozen", 32'(hist[3]), 32'h8);
        chk("bp_release", 32'(hist[4]), 32'h0);

        // Reset in the middle of requester 1's burst, with rr_ptr moved to 1.
        do_reset();
        push(0, 8'h01, 1'b1);
        push(0, 8'h02, 1'b1);
        for (int k = 0; k < 10; k++) push(1, 8'(8'h30 + k), 1'b0);
        en_mask = '1;
        tx_ready = 1'b1;
        for (int k = 0; k < 40 && rd[1] < 4; k++) step();
        chk("midrst_reached_byte5", 32'(rd[1]), 32'd4);
        reset = 1'b1;
        step();
        reset = 1'b0;
        peek();
        chk("midrst_grant", 32'(grant), 32'h0);
        chk("midrst_tx_valid", 32'(tx_valid), 32'h0);
        chk("midrst_req_ready", 32'(req_ready), 32'h0);
        step();
        chk("midrst_rr_ptr0", 32'(hist[hist.size()-1]), 32'h1);

        // Owner goes silent after one byte.
        do_reset();
        push(0, 8'h77, 1'b0);
        en_mask = '1;
        hist.delete();
        th.delete();
        repeat (120) step();
`ifdef UART_ARB_TIMEOUT_EN
        chk("to_held_before", 32'(hist[8]), 32'h1);
        chk("to_release", 32'(hist[9]), 32'h0);
        chk("to_evt_pulse", 32'(th[9]), 32'h1);
        chk("to_evt_single", 32'(th[10]), 32'h0);
`else
        ones = 0;
        foreach (th[k]) if (th[k] !== 1'b0) ones++;
        chk("hold_grant_120", 32'(hist[119]), 32'h1);
        chk("hold_no_timeout", 32'(ones), 32'd0);
`endif

        // Random traffic: message lengths straddle MAX_BURST, random gaps.
        do_reset();
        for (int i = 0; i < N; i++) begin
            while (wr[i] < 100) begin
                len = $urandom_range(1, 20);
                for (int b = 0; b < len; b++) push(i, 8'($urandom), b == len - 1);
            end
        end
        repeat (500) begin
            en_mask = 4'($urandom | $urandom);
            tx_ready = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of byte requesters sharing one transmit UART (legal 2..8).
REQ-002 SHALL have parameter MAX_BURST, default 16, maximum bytes one requester may send per grant (legal 1..255).
REQ-003 SHALL have parameter IDLE_TIMEOUT, default 1024, stall cycles before forced release (used only with UART_ARB_TIMEOUT_EN).
REQ-004 clk  input  1  sole clock, all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 req_valid  input  NUM_REQ  requester i has a byte on its data slice.
REQ-007 req_data  input  8*NUM_REQ  byte of requester i at bits [8i+7:8i].
REQ-008 req_last  input  NUM_REQ  byte of requester i ends its message.
REQ-009 req_ready  output  NUM_REQ  byte of requester i accepted this cycle.
REQ-010 tx_ready  input  1  transmit UART can accept a byte this cycle.
REQ-011 tx_valid  output  1  byte presented to transmit UART.
REQ-012 tx_data  output  8  byte to transmit UART.
REQ-013 grant  output  NUM_REQ  one-hot registered owner, all-zero when idle.
REQ-014 timeout_evt  output  1  one-cycle pulse on forced release by stall timeout.

Function
REQ-015 SHALL implement two states: IDLE (grant==0) and OWN (exactly one grant bit set).
REQ-016 In IDLE, if any req_valid is high, SHALL grant the first index at or above rr_ptr (wrapping modulo NUM_REQ) and enter OWN on the next edge; otherwise stay IDLE.
REQ-017 Grant latency SHALL be exactly one cycle: req_valid at edge N gives grant at N+1; first byte accepted no earlier than cycle N+1.
REQ-018 In OWN with owner g: tx_valid = req_valid[g], tx_data = req_data[g] slice, req_ready[g] = tx_ready, all combinational; in IDLE tx_valid=0, tx_data=0, req_ready=0.
REQ-019 A transfer SHALL occur exactly when OWN & req_valid[g] & tx_ready; req_ready of non-owners SHALL be 0 always.
REQ-020 Burst counter (width sufficient for MAX_BURST) SHALL clear on grant and increment on each transfer.
REQ-021 Release SHALL occur on the edge after a transfer with req_last[g]=1, or a transfer that makes the count equal MAX_BURST; both together cause a single release.
REQ-022 On release: grant<=0, state<=IDLE, rr_ptr<=(g+1) mod NUM_REQ; one IDLE cycle always separates consecutive owners.
REQ-023 Owner deasserting req_valid in OWN SHALL keep the grant (no release) unless the stall timeout applies.
REQ-024 tx_ready low SHALL freeze counter and grant; no byte lost or duplicated.
REQ-025 A requester with req_valid low at arbitration SHALL be skipped; rr_ptr changes only on release.

Reset
REQ-026 While reset is high at an edge: state=IDLE, grant=0, rr_ptr=0, burst counter=0, stall counter=0, timeout_evt=0.
REQ-027 Reset mid-burst SHALL drop the grant; tx_valid and req_ready SHALL be 0 from the cycle after the reset edge until a new grant.

Configuration
REQ-028 Macro UART_ARB_TIMEOUT_EN defined: stall counter SHALL count OWN cycles with req_valid[g]=0, clear on any cycle req_valid[g]=1, and on reaching IDLE_TIMEOUT release per REQ-022 and pulse timeout_evt for one cycle.
REQ-029 Macro UART_ARB_TIMEOUT_EN undefined: no stall counter logic, owner holds indefinitely, timeout_evt tied to 0.

Verification
REQ-030 After reset, req_valid=4'b0101, tx_ready=1 -> grant=4'b0001 one cycle later; requester 0 sends 3 bytes, last on 3rd -> release, idle cycle, grant=4'b0100.
REQ-031 Requester 1 streams 20 bytes without req_last, MAX_BURST=16 -> exactly 16 bytes on tx_data in order, then release, rr_ptr=2.
REQ-032 tx_ready toggled 1,0,0,1 during burst of bytes 0xA5,0x5A -> tx_data sequence exactly 0xA5,0x5A, no duplicates, count=2.
REQ-033 Reset asserted during byte 5 of a burst -> grant=0 and tx_valid=0 next cycle; rr_ptr=0 afterwards.
REQ-034 With UART_ARB_TIMEOUT_EN, IDLE_TIMEOUT=8, owner drops req_valid -> release and timeout_evt=1 for one cycle 8 cycles later; without macro grant held >100 cycles, timeout_evt=0.
